mem_arbiter: RTL

- Memory-side responder for the per-CPU cache request bus. Accepts instruction and data requests from the icache/dcache pairs of CPUS cores and serialises them onto one single-ported RAM.
- Returns wait/load responses to each requester.
- Sits between the caches blocks and the RAM model/wrapper. Exactly one RAM transaction is outstanding at a time.

---
 rtl/cpu_types_pkg.sv | 23 ++
 rtl/arb_select.sv | 44 ++++
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the cache-to-RAM arbitration path.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_t;

  typedef enum logic {
    IPORT,
    DPORT
  } port_sel_t;

endpackage

// File: rtl/arb_select.sv
// Combinational round-robin picker across cores; within a core dWEN > dREN > iREN.
module arb_select
  import cpu_types_pkg::*;
#(
  parameter int unsigned CPUS = 2,
  localparam int unsigned IdxW = (CPUS > 1) ? $clog2(CPUS) : 1
) (
  input  logic [CPUS-1:0] iren_i,
  input  logic [CPUS-1:0] dren_i,
  input  logic [CPUS-1:0] dwen_i,
  input  logic [IdxW-1:0] rr_i,
  output logic            valid_o,
  output logic [IdxW-1:0] core_o,
  output port_sel_t       port_o,
  output logic            wen_o
);

  logic [IdxW-1:0] idx;

  always_comb begin
    valid_o = 1'b0;
    core_o  = '0;
    port_o  = IPORT;
    wen_o   = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < CPUS; k++) begin
      idx = IdxW'((32'(rr_i) + k) % CPUS);
      // First core at or after the pointer with anything pending wins.
      if (!valid_o && (dwen_i[idx] || dren_i[idx] || iren_i[idx])) begin
        valid_o = 1'b1;
        core_o  = idx;
        if (dwen_i[idx]) begin
          port_o = DPORT;
          wen_o  = 1'b1;
        end else if (dren_i[idx]) begin
          port_o = DPORT;
        end else begin
          port_o = IPORT;
        end
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises per-core i/d cache requests onto one single-ported RAM, one transaction at a time.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned CPUS    = 2,
  parameter word_t       ERRWORD = 32'hBAD1BAD1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [CPUS-1:0]   iREN,
  input  logic [CPUS-1:0]   dREN,
  input  logic [CPUS-1:0]   dWEN,
  input  word_t [CPUS-1:0]  iaddr,
  input  word_t [CPUS-1:0]  daddr,
  input  word_t [CPUS-1:0]  dstore,
  output logic [CPUS-1:0]   iwait,
  output logic [CPUS-1:0]   dwait,
  output word_t [CPUS-1:0]  iload,
  output word_t [CPUS-1:0]  dload,
  output logic              ramREN,
  output logic              ramWEN,
  output word_t             ramaddr,
  output word_t             ramstore,
  input  word_t             ramload,
  input  ramstate_t         ramstate,
  output logic              ram_err
);

  localparam int unsigned IdxW = (CPUS > 1) ? $clog2(CPUS) : 1;

  arb_state_t       state_q;
  logic [IdxW-1:0]  rr_q;
  logic [IdxW-1:0]  g_core_q;
  port_sel_t        g_port_q;
  logic             g_wen_q;
  word_t            g_addr_q;
  word_t            g_store_q;
  logic             ram_err_q;
  word_t [CPUS-1:0] iload_q;
  word_t [CPUS-1:0] dload_q;

  logic             sel_valid;
  logic [IdxW-1:0]  sel_core;
  port_sel_t        sel_port;
  logic             sel_wen;

  logic             req_alive;
  logic             ram_done;
  logic             done;
  word_t            resp;

  arb_select #(
    .CPUS (CPUS)
  ) u_select (
    .iren_i  (iREN),
    .dren_i  (dREN),
    .dwen_i  (dWEN),
    .rr_i    (rr_q),
    .valid_o (sel_valid),
    .core_o  (sel_core),
    .port_o  (sel_port),
    .wen_o   (sel_wen)
  );

  // A granted request that drops before completion is an abort.
  assign req_alive = (g_port_q == IPORT) ? iREN[g_core_q] :
                     (g_wen_q ? dWEN[g_core_q] : dREN[g_core_q]);
  assign ram_done  = (ramstate == ACCESS) || (ramstate == ERROR);
  assign done      = (state_q == GRANT) && req_alive && ram_done;
  assign resp      = (ramstate == ERROR) ? ERRWORD : ramload;

  assign ramREN   = (state_q == GRANT) && !g_wen_q;
  assign ramWEN   = (state_q == GRANT) && g_wen_q;
  assign ramaddr  = (state_q == GRANT) ? g_addr_q : '0;
  assign ramstore = (state_q == GRANT) ? g_store_q : '0;
  assign ram_err  = ram_err_q;

  always_comb begin
    iwait = '1;
    dwait = '1;
    iload = iload_q;
    dload = dload_q;
    if (done) begin
      if (g_port_q == IPORT) begin
        iwait[g_core_q] = 1'b0;
        iload[g_core_q] = resp;
      end else begin
        dwait[g_core_q] = 1'b0;
        if (!g_wen_q) begin
          dload[g_core_q] = resp;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      g_core_q  <= '0;
      g_port_q  <= IPORT;
      g_wen_q   <= 1'b0;
      g_addr_q  <= '0;
      g_store_q <= '0;
      ram_err_q <= 1'b0;
      iload_q   <= '0;
      dload_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (sel_valid) begin
            g_core_q  <= sel_core;
            g_port_q  <= sel_port;
            g_wen_q   <= sel_wen;
            g_addr_q  <= (sel_port == IPORT) ? iaddr[sel_core] : daddr[sel_core];
            g_store_q <= sel_wen ? dstore[sel_core] : '0;
            rr_q      <= (32'(sel_core) == CPUS - 1) ? '0 : sel_core + 1'b1;
            state_q   <= GRANT;
          end
        end
        GRANT: begin
          if (!req_alive) begin
            state_q <= IDLE;
          end else if (ram_done) begin
            state_q <= IDLE;
            if (ramstate == ERROR) begin
              ram_err_q <= 1'b1;
            end
            if (g_port_q == IPORT) begin
              iload_q[g_core_q] <= resp;
            end else if (!g_wen_q) begin
              dload_q[g_core_q] <= resp;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
